// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback requesters (A = execute,
// B = load return) onto the single RegFile write port through one register
// stage. It also keeps a pending-load scoreboard for decode hazard checks.
// Optional feature macro: WB_AGING_EN. When it is defined, a starvation
// counter lets port B win over port A after STARVE_MAX lost cycles.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_waddr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_waddr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  input  logic              ld_issue_i,
  input  logic [ADDR_W-1:0] ld_rd_i,
  input  logic [ADDR_W-1:0] chk_rs1_i,
  input  logic [ADDR_W-1:0] chk_rs2_i,
  input  logic [ADDR_W-1:0] chk_rd_i,
  output logic              hazard_o,
  output logic              rf_wen_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_data_o
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic              b_prio;
  logic              a_xfer;
  logic              b_xfer;

  logic              rf_wen_q,   rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_data_q,  rf_data_d;
  logic [NREG-1:0]   pend_q,     pend_d;

`ifdef WB_AGING_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  // B takes priority once it has waited STARVE_MAX cycles and is still asking
  always_comb begin
    b_prio = b_valid_i && (starve_q == CNT_MAX);
  end

  // Starvation counter: count lost cycles, saturate, clear on accept or idle
  always_comb begin
    starve_d = starve_q;
    if (!b_valid_i || b_ready_o) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict A > B priority; B can starve under continuous A traffic
  always_comb begin
    b_prio = 1'b0;
  end
`endif

  // Single combinational grant per cycle, A first unless B is aged
  always_comb begin
    a_ready_o = a_valid_i && !b_prio;
    b_ready_o = b_valid_i && (!a_valid_i || b_prio);
    a_xfer    = a_ready_o;
    b_xfer    = b_ready_o;
  end

  // Write-stage next state: x0 transfers complete but never raise wen
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_data_d  = rf_data_q;
    if (a_xfer && (a_waddr_i != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = a_waddr_i;
      rf_data_d  = a_data_i;
    end else if (b_xfer && (b_waddr_i != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = b_waddr_i;
      rf_data_d  = b_data_i;
    end
  end

  // Scoreboard next state: clear applied first so a same-cycle set wins
  always_comb begin
    pend_d = pend_q;
    if (b_xfer) begin
      pend_d[b_waddr_i] = 1'b0;
    end
    if (ld_issue_i && (ld_rd_i != '0)) begin
      pend_d[ld_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Hazard from registered scoreboard only; x0 never reports pending
  always_comb begin
    hazard_o = ((chk_rs1_i != '0) && pend_q[chk_rs1_i]) ||
               ((chk_rs2_i != '0) && pend_q[chk_rs2_i]) ||
               ((chk_rd_i  != '0) && pend_q[chk_rd_i]);
  end

  // Write stage and scoreboard registers; reset drops any in-flight write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_data_q  <= '0;
      pend_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_data_q  <= rf_data_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    rf_wen_o   = rf_wen_q;
    rf_waddr_o = rf_waddr_q;
    rf_data_o  = rf_data_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus pushes expected RegFile
// writes into a queue; a negedge monitor pops and compares each write.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              a_valid_i;
  logic [ADDR_W-1:0] a_waddr_i;
  logic [DATA_W-1:0] a_data_i;
  logic              a_ready_o;
  logic              b_valid_i;
  logic [ADDR_W-1:0] b_waddr_i;
  logic [DATA_W-1:0] b_data_i;
  logic              b_ready_o;
  logic              ld_issue_i;
  logic [ADDR_W-1:0] ld_rd_i;
  logic [ADDR_W-1:0] chk_rs1_i;
  logic [ADDR_W-1:0] chk_rs2_i;
  logic [ADDR_W-1:0] chk_rd_i;
  logic              hazard_o;
  logic              rf_wen_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_data_o;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  regfile_wb_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_valid_i  (a_valid_i),
    .a_waddr_i  (a_waddr_i),
    .a_data_i   (a_data_i),
    .a_ready_o  (a_ready_o),
    .b_valid_i  (b_valid_i),
    .b_waddr_i  (b_waddr_i),
    .b_data_i   (b_data_i),
    .b_ready_o  (b_ready_o),
    .ld_issue_i (ld_issue_i),
    .ld_rd_i    (ld_rd_i),
    .chk_rs1_i  (chk_rs1_i),
    .chk_rs2_i  (chk_rs2_i),
    .chk_rd_i   (chk_rd_i),
    .hazard_o   (hazard_o),
    .rf_wen_o   (rf_wen_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_data_o  (rf_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every RegFile write must match the oldest expected write
  always @(negedge clk_i) begin
    if (!rst_i && rf_wen_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 64'(rf_waddr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 64'(rf_waddr_o), 64'(w.addr));
        chk("wr_data", 64'(rf_data_o), 64'(w.data));
      end
    end
  end

  initial begin
    logic exp_b;
    logic [DATA_W-1:0] bdat;

    rst_i = 1'b1;
    a_valid_i = 1'b1; a_waddr_i = 5'd3; a_data_i = 32'h1111_1111;
    b_valid_i = 1'b1; b_waddr_i = 5'd4; b_data_i = 32'h2222_2222;
    ld_issue_i = 1'b1; ld_rd_i = 5'd9;
    chk_rs1_i = 5'd9; chk_rs2_i = 5'd5; chk_rd_i = 5'd31;

    // Reset held two cycles with both requesters and a load active
    step();
    step();
    rst_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; ld_issue_i = 1'b0;
    #1;
    chk("rst_wen", 64'(rf_wen_o), 64'd0);
    chk("rst_waddr", 64'(rf_waddr_o), 64'd0);
    chk("rst_data", 64'(rf_data_o), 64'd0);
    chk("rst_hazard", 64'(hazard_o), 64'd0);
    chk("rst_a_ready", 64'(a_ready_o), 64'd0);
    chk("rst_b_ready", 64'(b_ready_o), 64'd0);
    step();
    chk("rst_wen_after", 64'(rf_wen_o), 64'd0);
    chk("rst_hazard_after", 64'(hazard_o), 64'd0);
    chk_rs1_i = '0; chk_rs2_i = '0; chk_rd_i = '0;

    // A only
    a_valid_i = 1'b1; a_waddr_i = 5'd5; a_data_i = 32'hDEAD_BEEF;
    #1;
    chk("aonly_a_ready", 64'(a_ready_o), 64'd1);
    chk("aonly_b_ready", 64'(b_ready_o), 64'd0);
    push(5'd5, 32'hDEAD_BEEF);
    step();
    a_valid_i = 1'b0;
    chk("aonly_wen1", 64'(rf_wen_o), 64'd1);
    step();
    chk("aonly_wen0", 64'(rf_wen_o), 64'd0);
    chk("aonly_hold_addr", 64'(rf_waddr_o), 64'd5);
    chk("aonly_hold_data", 64'(rf_data_o), 64'hDEAD_BEEF);

    // Contention on the same address
    a_valid_i = 1'b1; a_waddr_i = 5'd7; a_data_i = 32'h1;
    b_valid_i = 1'b1; b_waddr_i = 5'd7; b_data_i = 32'h2;
    #1;
    chk("cont_a_ready", 64'(a_ready_o), 64'd1);
    chk("cont_b_ready", 64'(b_ready_o), 64'd0);
    push(5'd7, 32'h1);
    step();
    a_valid_i = 1'b0;
    #1;
    chk("cont_b_ready2", 64'(b_ready_o), 64'd1);
    push(5'd7, 32'h2);
    step();
    b_valid_i = 1'b0;
    step();

    // Write to x0: accepted but no RegFile write
    a_valid_i = 1'b1; a_waddr_i = 5'd0; a_data_i = 32'h55;
    #1;
    chk("x0_a_ready", 64'(a_ready_o), 64'd1);
    step();
    a_valid_i = 1'b0;
    chk("x0_wen", 64'(rf_wen_o), 64'd0);
    step();

    // Scoreboard set, all three check ports, clear by B write
    ld_issue_i = 1'b1; ld_rd_i = 5'd9; chk_rs1_i = 5'd9;
    #1;
    chk("sb_no_bypass", 64'(hazard_o), 64'd0);
    step();
    ld_issue_i = 1'b0;
    #1;
    chk("sb_rs1", 64'(hazard_o), 64'd1);
    chk_rs1_i = '0; chk_rs2_i = 5'd9;
    #1;
    chk("sb_rs2", 64'(hazard_o), 64'd1);
    chk_rs2_i = '0; chk_rd_i = 5'd9;
    #1;
    chk("sb_rd", 64'(hazard_o), 64'd1);
    chk_rd_i = '0; chk_rs2_i = 5'd8;
    #1;
    chk("sb_other_reg", 64'(hazard_o), 64'd0);
    chk_rs2_i = '0; chk_rs1_i = 5'd9;
    b_valid_i = 1'b1; b_waddr_i = 5'd9; b_data_i = 32'hAA;
    #1;
    chk("sb_b_ready", 64'(b_ready_o), 64'd1);
    chk("sb_still_pend", 64'(hazard_o), 64'd1);
    push(5'd9, 32'hAA);
    step();
    b_valid_i = 1'b0;
    #1;
    chk("sb_cleared", 64'(hazard_o), 64'd0);

    // Load to x0 never sets pending
    ld_issue_i = 1'b1; ld_rd_i = 5'd0; chk_rs1_i = 5'd0;
    step();
    ld_issue_i = 1'b0;
    #1;
    chk("sb_x0", 64'(hazard_o), 64'd0);

    // Set/clear collision: set wins
    chk_rs1_i = 5'd9;
    ld_issue_i = 1'b1; ld_rd_i = 5'd9;
    step();
    ld_issue_i = 1'b0;
    chk("coll_pre", 64'(hazard_o), 64'd1);
    ld_issue_i = 1'b1; ld_rd_i = 5'd9;
    b_valid_i = 1'b1; b_waddr_i = 5'd9; b_data_i = 32'hBB;
    #1;
    chk("coll_b_ready", 64'(b_ready_o), 64'd1);
    push(5'd9, 32'hBB);
    step();
    ld_issue_i = 1'b0;
    b_data_i = 32'hCC;
    #1;
    chk("coll_set_wins", 64'(hazard_o), 64'd1);
    push(5'd9, 32'hCC);
    step();
    b_valid_i = 1'b0;
    #1;
    chk("coll_final_clear", 64'(hazard_o), 64'd0);

    // Continuous A and B traffic: aging grants B on the 4th cycle
    b_valid_i = 1'b1; b_waddr_i = 5'd11; bdat = 32'h200; b_data_i = bdat;
    a_valid_i = 1'b1; a_waddr_i = 5'd10;
    for (int i = 0; i < 6; i++) begin
      a_data_i = 32'h100 + 32'(i);
`ifdef WB_AGING_EN
      exp_b = (i == 3);
`else
      exp_b = 1'b0;
`endif
      #1;
      chk("age_a_ready", 64'(a_ready_o), 64'(!exp_b));
      chk("age_b_ready", 64'(b_ready_o), 64'(exp_b));
      if (exp_b) push(5'd11, bdat);
      else       push(5'd10, a_data_i);
      step();
      if (exp_b) begin
        bdat = bdat + 32'd1;
        b_data_i = bdat;
      end
    end
    a_valid_i = 1'b0;
    #1;
    chk("age_b_after_a", 64'(b_ready_o), 64'd1);
    push(5'd11, bdat);
    step();
    b_valid_i = 1'b0;
    step();

    // Reset mid-operation drops the in-flight write and pending bits
    ld_issue_i = 1'b1; ld_rd_i = 5'd9;
    step();
    ld_issue_i = 1'b0;
    chk("midrst_pend", 64'(hazard_o), 64'd1);
    rst_i = 1'b1;
    a_valid_i = 1'b1; a_waddr_i = 5'd12; a_data_i = 32'h77;
    step();
    rst_i = 1'b0; a_valid_i = 1'b0;
    #1;
    chk("midrst_wen", 64'(rf_wen_o), 64'd0);
    chk("midrst_hazard", 64'(hazard_o), 64'd0);
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
